// File: rtl/mem_dump_reader.sv
// ---------------------------------------------------------------------------
// mem_dump_reader
//
// Debug read-back initiator for the data-memory block RAM. When start is
// accepted, the block walks word_count words from base_addr on the RAM's spare
// read port. Addresses wrap modulo 2^ADDR_WIDTH. Each word goes out MSB byte
// first on a valid/ready byte stream toward the UART transmitter. When enabled,
// an XOR-of-all-bytes checksum byte follows the last word. done then pulses for
// one cycle.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high
//   start       one-cycle request, honoured only while idle
//   base_addr   first word address, captured on an accepted start
//   word_count  number of words (0 .. 2^ADDR_WIDTH), captured on start
//   mem_addr    registered read address to the RAM port
//   mem_we      RAM write enable, tied low
//   mem_rdata   RAM read data, valid READ_LATENCY cycles after the address
//   tx_data     byte to the transmitter
//   tx_valid    tx_data is valid
//   tx_ready    transmitter accepts the byte this cycle
//   busy        dump in progress
//   done        one-cycle completion pulse
// ---------------------------------------------------------------------------
module mem_dump_reader #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_LATENCY  = 1,
    parameter int SEND_CHECKSUM = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
    // WAIT covers READ_LATENCY-1 cycles, so it exits when the count reaches
    // READ_LATENCY-2.
    localparam logic [1:0] WAIT_LAST = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_CSUM    = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;

    logic [2:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic [BIDX_W-1:0]     byte_idx_q,  byte_idx_d;
    logic [1:0]            wait_cnt_q,  wait_cnt_d;
    logic [7:0]            csum_q,      csum_d;

    logic [7:0] head_byte;
    assign head_byte = shift_q[DATA_WIDTH-1 -: 8];

    always_comb begin
        // NOTE: every _d gets its hold value first, so any path through the case
        // below that does not assign a _d cannot infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        remaining_d = remaining_q;
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;
        wait_cnt_d  = wait_cnt_q;
        csum_d      = csum_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = word_count;
                    csum_d      = 8'h00;
                    if (word_count == '0) begin
                        state_d = (SEND_CHECKSUM != 0) ? S_CSUM : S_FINISH;
                    end else begin
                        state_d    = S_FETCH;
                        mem_addr_d = base_addr;
                    end
                end
            end
            // The RAM samples mem_addr at the end of FETCH. mem_addr is loaded
            // on the way in, so it already holds addr_q during FETCH.
            S_FETCH: begin
                if (READ_LATENCY > 1) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 2'd0;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_CAPTURE: begin
                shift_d     = mem_rdata;
                byte_idx_d  = '0;
                addr_d      = addr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    csum_d     = csum_q ^ head_byte;
                    shift_d    = shift_q << 8;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == LAST_BYTE) begin
                        if (remaining_q != '0) begin
                            state_d    = S_FETCH;
                            mem_addr_d = addr_q;
                        end else begin
                            state_d = (SEND_CHECKSUM != 0) ? S_CSUM : S_FINISH;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (tx_ready) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments, so each register takes its next value
        // from the pre-edge state of all the others, whatever the order here.
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            remaining_q <= '0;
            shift_q     <= '0;
            byte_idx_q  <= '0;
            wait_cnt_q  <= '0;
            csum_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            remaining_q <= remaining_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            csum_q      <= csum_d;
        end
    end

    // The outputs are plain decodes of registered state.
    assign mem_addr = mem_addr_q;
    assign mem_we   = 1'b0;
    assign tx_valid = (state_q == S_SEND) || (state_q == S_CSUM);
    assign tx_data  = (state_q == S_SEND) ? head_byte :
                      (state_q == S_CSUM) ? csum_q    : 8'h00;
    assign busy     = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done     = (state_q == S_FINISH);

endmodule

// File: tb/tb_mem_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_mem_dump_reader
//
// Three readers run side by side from one stimulus stream, each on its own RAM
// model:
//   g0  READ_LATENCY 1, checksum on
//   g1  READ_LATENCY 3, checksum on
//   g2  READ_LATENCY 1, checksum off
// A negedge monitor records the accepted bytes, the done pulses, the distinct
// mem_addr values seen while busy, and any change of a stalled byte. Each dump
// is then compared with a stream built directly from the memory image.
// ---------------------------------------------------------------------------
module tb_mem_dump_reader;

    localparam int NDUT = 3;

    logic        clock;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic        tx_ready;

    logic [9:0]  mem_addr  [NDUT];
    logic        mem_we    [NDUT];
    logic [31:0] mem_rdata [NDUT];
    logic [7:0]  tx_data   [NDUT];
    logic        tx_valid  [NDUT];
    logic        busy      [NDUT];
    logic        done      [NDUT];

    logic [31:0] mem [1024];
    logic [31:0] p1 [NDUT];
    logic [31:0] p2 [NDUT];
    logic [31:0] p3 [NDUT];

    int tests  = 0;
    int failed = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_dump_reader #(
            .ADDR_WIDTH   (10),
            .DATA_WIDTH   (32),
            .READ_LATENCY ((g == 1) ? 3 : 1),
            .SEND_CHECKSUM((g == 2) ? 0 : 1)
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .start     (start),
            .base_addr (base_addr),
            .word_count(word_count),
            .mem_addr  (mem_addr[g]),
            .mem_we    (mem_we[g]),
            .mem_rdata (mem_rdata[g]),
            .tx_data   (tx_data[g]),
            .tx_valid  (tx_valid[g]),
            .tx_ready  (tx_ready),
            .busy      (busy[g]),
            .done      (done[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read RAM with a 1- or 3-cycle read pipeline.
    always @(posedge clock) begin
        for (int g = 0; g < NDUT; g++) begin
            p1[g] <= mem[mem_addr[g]];
            p2[g] <= p1[g];
            p3[g] <= p2[g];
        end
    end
    always_comb begin
        for (int g = 0; g < NDUT; g++) begin
            mem_rdata[g] = (g == 1) ? p3[g] : p1[g];
        end
    end

    // Monitor state
    logic       clr;
    int         cyc = 0;
    int         got_n     [NDUT];
    logic [7:0] got_mem   [NDUT][64];
    int         done_cnt  [NDUT];
    int         done_cyc  [NDUT];
    int         stall_err [NDUT];
    int         addr_n    [NDUT];
    logic [9:0] addr_log  [NDUT][16];
    logic       prev_stall[NDUT];
    logic [7:0] prev_data [NDUT];

    always @(negedge clock) begin
        cyc = cyc + 1;
        for (int g = 0; g < NDUT; g++) begin
            if (clr) begin
                got_n[g]      = 0;
                done_cnt[g]   = 0;
                done_cyc[g]   = 0;
                stall_err[g]  = 0;
                addr_n[g]     = 0;
                prev_stall[g] = 1'b0;
            end else begin
                if (prev_stall[g] && (tx_valid[g] !== 1'b1 || tx_data[g] !== prev_data[g]))
                    stall_err[g] = stall_err[g] + 1;
                prev_stall[g] = tx_valid[g] && !tx_ready;
                prev_data[g]  = tx_data[g];
                if (tx_valid[g] && tx_ready) begin
                    if (got_n[g] < 64) got_mem[g][got_n[g]] = tx_data[g];
                    got_n[g] = got_n[g] + 1;
                end
                if (done[g]) begin
                    done_cnt[g] = done_cnt[g] + 1;
                    done_cyc[g] = cyc;
                end
                if (busy[g] && addr_n[g] < 16) begin
                    if (addr_n[g] == 0 || mem_addr[g] != addr_log[g][addr_n[g]-1]) begin
                        addr_log[g][addr_n[g]] = mem_addr[g];
                        addr_n[g] = addr_n[g] + 1;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            failed = failed + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit all_done();
        for (int g = 0; g < NDUT; g++) if (done_cnt[g] < 1) return 1'b0;
        return 1'b1;
    endfunction

    // One full dump: start, drive tx_ready, wait for every done (bounded),
    // then compare each reader with a stream built from the memory image.
    task automatic run_dump(input int base, input int cnt, input bit rnd_ready, input bit inject);
        int  t0;
        bit  ok;
        logic [7:0] exp_b[$];
        logic [7:0] cs;
        logic [31:0] w;
        string nm;
        @(posedge clock); #1;
        clr = 1'b1; tx_ready = 1'b1;
        @(posedge clock); #1;
        clr = 1'b0;
        start = 1'b1; base_addr = base[9:0]; word_count = cnt[10:0];
        t0 = cyc;
        @(posedge clock); #1;
        start = 1'b0;
        // The readers must have captured the inputs already.
        base_addr = 10'($urandom); word_count = 11'($urandom);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (all_done()) begin ok = 1'b1; break; end
            if (inject && k == 4) begin
                start = 1'b1; base_addr = 10'(base + 7); word_count = 11'd1;
            end else begin
                start = 1'b0;
            end
            tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clock); #1;
        end
        start = 1'b0; tx_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        nm = $sformatf("b%0d_c%0d", base, cnt);
        check({nm, " completion"}, 32'(ok), 32'd1);
        for (int g = 0; g < NDUT; g++) begin
            exp_b = {};
            cs = 8'h00;
            for (int i = 0; i < cnt; i++) begin
                w = mem[(base + i) % 1024];
                for (int b = 3; b >= 0; b--) begin
                    exp_b.push_back(w[b*8 +: 8]);
                    cs = cs ^ w[b*8 +: 8];
                end
            end
            if (g != 2) exp_b.push_back(cs);
            check($sformatf("%s g%0d byte_count", nm, g), 32'(got_n[g]), 32'(exp_b.size()));
            for (int i = 0; i < exp_b.size() && i < 64; i++)
                check($sformatf("%s g%0d byte%0d", nm, g, i), 32'(got_mem[g][i]), 32'(exp_b[i]));
            check($sformatf("%s g%0d done_pulses", nm, g), 32'(done_cnt[g]), 32'd1);
            check($sformatf("%s g%0d stall_stable", nm, g), 32'(stall_err[g]), 32'd0);
            if (cnt > 0) begin
                check($sformatf("%s g%0d addr_count", nm, g), 32'(addr_n[g]), 32'(cnt));
                for (int i = 0; i < cnt && i < 16; i++)
                    check($sformatf("%s g%0d addr%0d", nm, g, i),
                          32'(addr_log[g][i]), 32'((base + i) % 1024));
            end else if (!rnd_ready) begin
                // One cycle to the CSUM byte, one to FINISH, done seen one later.
                check($sformatf("%s g%0d done_latency_ok", nm, g),
                      32'((done_cyc[g] - t0) <= ((g == 2) ? 2 : 3)), 32'd1);
            end
        end
    endtask

    initial begin
        bit hit;
        reset = 1'b1; start = 1'b0; tx_ready = 1'b0; clr = 1'b0;
        base_addr = '0; word_count = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[5]    = 32'h11223344;
        mem[6]    = 32'hAABBCCDD;
        mem[1023] = 32'h01020304;
        mem[0]    = 32'h05060708;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("reset g%0d mem_addr", g), 32'(mem_addr[g]), 32'd0);
            check($sformatf("reset g%0d mem_we", g),   32'(mem_we[g]),   32'd0);
            check($sformatf("reset g%0d tx_data", g),  32'(tx_data[g]),  32'd0);
            check($sformatf("reset g%0d tx_valid", g), 32'(tx_valid[g]), 32'd0);
            check($sformatf("reset g%0d busy", g),     32'(busy[g]),     32'd0);
            check($sformatf("reset g%0d done", g),     32'(done[g]),     32'd0);
        end

        run_dump(5, 2, 1'b0, 1'b0);
        run_dump(5, 2, 1'b1, 1'b0);
        run_dump(1023, 2, 1'b0, 1'b0);
        run_dump(1023, 2, 1'b1, 1'b0);
        run_dump(100, 0, 1'b0, 1'b0);

        // Reset while the third byte of a 4-word dump is on the stream.
        @(posedge clock); #1;
        clr = 1'b1; tx_ready = 1'b1;
        @(posedge clock); #1;
        clr = 1'b0; start = 1'b1; base_addr = 10'd5; word_count = 11'd4;
        @(posedge clock); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (got_n[0] >= 2) begin hit = 1'b1; break; end
            @(posedge clock); #1;
        end
        check("midreset reached_third_byte", 32'(hit), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("midreset g%0d tx_valid", g), 32'(tx_valid[g]), 32'd0);
            check($sformatf("midreset g%0d busy", g),     32'(busy[g]),     32'd0);
            check($sformatf("midreset g%0d done", g),     32'(done[g]),     32'd0);
            check($sformatf("midreset g%0d no_done", g),  32'(done_cnt[g]), 32'd0);
        end
        run_dump(5, 1, 1'b0, 1'b0);

        // A start pulse in the middle of a dump must be ignored.
        run_dump(5, 3, 1'b1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            run_dump(int'($urandom_range(0, 1023)), int'($urandom_range(1, 6)), 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
